// File: rtl/demo_avalon_memory.sv
// Avalon-MM slave word memory with byte enables; optionally replays the enabled bytes of
// each accepted write on an Avalon-ST byte source, lane 0 first.
module demo_avalon_memory #(
  parameter int unsigned AV_ADDRESS_W         = 16,
  parameter int unsigned AV_DATA_W            = 32,
  parameter int unsigned AV_NUMSYMBOLS        = 4,
  parameter int unsigned ENABLE_STREAM_OUTPUT = 1,
  parameter int unsigned MEM_DEPTH            = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     avs_write,
  input  logic                     avs_read,
  output logic                     avs_waitrequest,
  input  logic [AV_ADDRESS_W-1:0]  avs_address,
  input  logic [AV_NUMSYMBOLS-1:0] avs_byteenable,
  input  logic [AV_DATA_W-1:0]     avs_writedata,
  output logic [AV_DATA_W-1:0]     avs_readdata,
  output logic                     aso_valid,
  output logic [7:0]               aso_data,
  input  logic                     aso_ready
);

  localparam int unsigned IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam bit          StreamEn = (ENABLE_STREAM_OUTPUT != 0);

  logic [AV_DATA_W-1:0]     mem_q [MEM_DEPTH];
  logic [IdxW-1:0]          idx;
  logic [AV_DATA_W-1:0]     pend_data_q, pend_data_d;
  logic [AV_NUMSYMBOLS-1:0] pend_mask_q, pend_mask_d;
  logic [AV_NUMSYMBOLS-1:0] head_lane;
  logic                     busy;
  logic                     accept;

  // Upper address bits alias onto the stored words.
  assign idx = avs_address[IdxW-1:0];

  if (AV_ADDRESS_W > IdxW) begin : g_addr_unused
    logic unused_addr;
    assign unused_addr = ^avs_address[AV_ADDRESS_W-1:IdxW];
  end

  assign busy            = |pend_mask_q;
  assign avs_waitrequest = avs_write & busy;
  assign accept          = avs_write & ~busy;
  assign aso_valid       = StreamEn & busy;
  assign avs_readdata    = avs_read ? mem_q[idx] : '0;

  // Lowest pending lane is the one on the stream output.
  always_comb begin
    head_lane = '0;
    aso_data  = '0;
    for (int unsigned k = 0; k < AV_NUMSYMBOLS; k++) begin
      if (pend_mask_q[k] && (head_lane == '0)) begin
        head_lane[k] = 1'b1;
        aso_data     = pend_data_q[8*k +: 8];
      end
    end
  end

  // A write is only accepted when nothing is pending, so load and drain never coincide.
  always_comb begin
    pend_mask_d = pend_mask_q;
    pend_data_d = pend_data_q;
    if (busy && aso_ready) begin
      pend_mask_d = pend_mask_q & ~head_lane;
    end
    if (StreamEn && accept) begin
      pend_mask_d = avs_byteenable;
      pend_data_d = avs_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_mask_q <= '0;
      pend_data_q <= '0;
    end else begin
      pend_mask_q <= pend_mask_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      for (int unsigned k = 0; k < AV_NUMSYMBOLS; k++) begin
        if (avs_byteenable[k]) begin
          mem_q[idx][8*k +: 8] <= avs_writedata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_demo_avalon_memory.sv
// Directed bench for demo_avalon_memory; stream bytes are checked against a scoreboard
// queue filled when each write is accepted.
module tb_demo_avalon_memory;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic        avs_waitrequest;
  logic [15:0] avs_address = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        aso_valid;
  logic [7:0]  aso_data;
  logic        aso_ready = 1'b1;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  demo_avalon_memory dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avs_write       (avs_write),
    .avs_read        (avs_read),
    .avs_waitrequest (avs_waitrequest),
    .avs_address     (avs_address),
    .avs_byteenable  (avs_byteenable),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .aso_valid       (aso_valid),
    .aso_data        (aso_data),
    .aso_ready       (aso_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // A beat seen valid&ready at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n && aso_valid && aso_ready) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 8'hxx;
      check("stream_byte", {24'h0, aso_data}, {24'h0, e});
    end
  end

  task automatic push_stream(input logic [31:0] d, input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) exp_q.push_back(d[8*k +: 8]);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int waits);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    waits          = 0;
    @(negedge clk);
    while (avs_waitrequest && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (avs_waitrequest) begin
      check("write_timeout", {31'h0, avs_waitrequest}, 32'h0);
      avs_write = 1'b0;
      return;
    end
    push_stream(d, be);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    check(tag, avs_readdata, exp);
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() > 0 || aso_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_queue", exp_q.size(), 32'h0);
    check("drain_valid", {31'h0, aso_valid}, 32'h0);
  endtask

  initial begin
    int w1, w2;

    // Reset values, with requests active to show they are masked.
    avs_write = 1'b1;
    avs_read  = 1'b1;
    #2;
    check("rst_waitrequest", {31'h0, avs_waitrequest}, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_aso_valid", {31'h0, aso_valid}, 32'h0);
    check("rst_aso_data", {24'h0, aso_data}, 32'h0);
    avs_write = 1'b0;
    avs_read  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    do_read("read_after_reset", 16'h0000, 32'h0);

    // Two-lane write: two consecutive beats, then back to idle.
    do_write(16'h0000, 32'hdead010a, 4'h3, w1);
    check("be3_waits", w1, 32'd0);
    @(negedge clk);
    check("be3_beat0", {23'h0, aso_valid, aso_data}, {23'h0, 1'b1, 8'h0a});
    @(negedge clk);
    check("be3_beat1", {23'h0, aso_valid, aso_data}, {23'h0, 1'b1, 8'h01});
    wait_drain();
    do_read("read_be3", 16'h0000, 32'h0000010a);

    // Back-to-back full words: second write stalls for four drain beats.
    do_write(16'h0001, 32'hdead010f, 4'hf, w1);
    do_write(16'h0002, 32'hdead0001, 4'hf, w2);
    check("b2b_first_waits", w1, 32'd0);
    check("b2b_second_waits", w2, 32'd4);
    wait_drain();
    do_read("read_w1", 16'h0001, 32'hdead010f);
    do_read("read_w2", 16'h0002, 32'hdead0001);

    // Partial lanes over a known pattern.
    do_write(16'h0003, 32'haaaaaaaa, 4'hf, w1);
    wait_drain();
    do_write(16'h0003, 32'h11223344, 4'h5, w1);
    wait_drain();
    do_read("read_be5", 16'h0003, 32'haa22aa44);

    // Empty byteenable: no update and no stream.
    do_write(16'h0003, 32'hffffffff, 4'h0, w1);
    check("be0_waits", w1, 32'd0);
    @(negedge clk);
    check("be0_no_valid", {31'h0, aso_valid}, 32'h0);
    do_read("read_be0", 16'h0003, 32'haa22aa44);

    // Simultaneous read and write returns pre-write data.
    avs_address    = 16'h0003;
    avs_writedata  = 32'h55667788;
    avs_byteenable = 4'hf;
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    @(negedge clk);
    check("rw_pre_write", avs_readdata, 32'haa22aa44);
    check("rw_no_wait", {31'h0, avs_waitrequest}, 32'h0);
    push_stream(32'h55667788, 4'hf);
    @(posedge clk);
    #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
    wait_drain();
    do_read("rw_post_write", 16'h0003, 32'h55667788);

    // Sink stall mid-word with a write waiting behind it.
    do_write(16'h0004, 32'hcafebabe, 4'hf, w1);
    @(posedge clk);
    #1;
    aso_ready      = 1'b0;
    avs_address    = 16'h0006;
    avs_writedata  = 32'h0badf00d;
    avs_byteenable = 4'hf;
    avs_write      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", {31'h0, aso_valid}, 32'h1);
      check("stall_data", {24'h0, aso_data}, 32'h000000ba);
      check("stall_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
    end
    @(posedge clk);
    #1;
    aso_ready = 1'b1;
    do_write(16'h0006, 32'h0badf00d, 4'hf, w2);
    check("stall_next_waits", w2, 32'd3);
    wait_drain();
    do_read("read_stall_w1", 16'h0004, 32'hcafebabe);
    do_read("read_stall_w2", 16'h0006, 32'h0badf00d);

    // Aliasing of upper address bits.
    do_write(16'h0100, 32'h12345678, 4'hf, w1);
    wait_drain();
    do_read("read_alias", 16'h0000, 32'h12345678);

    // Asynchronous reset in the middle of a word.
    do_write(16'h0005, 32'h01020304, 4'hf, w1);
    @(posedge clk);
    #3;
    avs_address = 16'h0005;
    avs_read    = 1'b1;
    avs_write   = 1'b1;
    reset_n     = 1'b0;
    #1;
    check("midrst_valid", {31'h0, aso_valid}, 32'h0);
    check("midrst_data", {24'h0, aso_data}, 32'h0);
    check("midrst_waitrequest", {31'h0, avs_waitrequest}, 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    exp_q.delete();
    avs_write = 1'b0;
    avs_read  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_read("postrst_read5", 16'h0005, 32'h0);
    do_read("postrst_read0", 16'h0000, 32'h0);
    check("end_queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
